// File: rtl/sram2p_ctrl_pkg.sv
// Shared types and helpers for two-port SRAM array controllers.
package sram2p_ctrl_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_t;

  // Number of byte-enable lanes covering a word; the top lane may be partial.
  function automatic int calc_bw(input int width);
    return (width - 1) / 8 + 1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer flips only on contention.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic ptr_reg;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_reg ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg <= 1'b0;
    end else if (&req) begin
      ptr_reg <= ~ptr_reg;
    end
  end

endmodule

// File: rtl/sram2p_ctrl.sv
// 1R/1W byte-enabled SRAM controller: init sweep, two-requester write
// arbitration and same-cycle write-to-read forwarding.
module sram2p_ctrl
  import sram2p_ctrl_pkg::*;
#(
  parameter int             DEPTH   = 1024,
  parameter int             WIDTH   = 68,
  parameter logic [WIDTH-1:0] INITVAL = '0,
  localparam int            BW      = calc_bw(WIDTH),
  localparam int            AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  output logic             busy,
  input  logic [1:0]       wvalid,
  output logic [1:0]       wready,
  input  logic [AW-1:0]    wadr0,
  input  logic [AW-1:0]    wadr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  input  logic [BW-1:0]    wbe0,
  input  logic [BW-1:0]    wbe1,
  input  logic             rreq,
  output logic             rready,
  input  logic [AW-1:0]    radr,
  output logic             rvalid,
  output logic [WIDTH-1:0] rdata,
  output logic             ce1,
  output logic [AW-1:0]    ra1,
  output logic             ce2,
  output logic             we2,
  output logic [AW-1:0]    wa2,
  output logic [WIDTH-1:0] wd2,
  output logic [BW-1:0]    bwe2,
  input  logic [WIDTH-1:0] rd1
);

  ctrl_state_t      state_reg;
  logic [AW-1:0]    cnt_reg;
  logic             rvalid_reg;
  logic             hit_reg;
  logic [WIDTH-1:0] fwd_data_reg;
  logic [BW-1:0]    fwd_be_reg;

  logic             run;
  logic [1:0]       grant;
  logic             wgrant;
  logic [AW-1:0]    sel_adr;
  logic [WIDTH-1:0] sel_data;
  logic [BW-1:0]    sel_be;
  logic             rd_fire;

  assign run = (state_reg == ST_RUN);

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (run ? wvalid : 2'b00),
    .grant (grant)
  );

  assign wgrant   = |grant;
  assign sel_adr  = grant[1] ? wadr1  : wadr0;
  assign sel_data = grant[1] ? wdata1 : wdata0;
  assign sel_be   = grant[1] ? wbe1   : wbe0;

  assign busy   = ~run;
  assign wready = grant;
  assign rready = run;
  assign rd_fire = run & rreq;

  assign ce1 = rd_fire;
  assign ra1 = radr;

  // The sweep owns the write port outright; arbitration only applies in RUN.
  assign ce2  = run ? wgrant   : 1'b1;
  assign we2  = run ? wgrant   : 1'b1;
  assign wa2  = run ? sel_adr  : cnt_reg;
  assign wd2  = run ? sel_data : INITVAL;
  assign bwe2 = run ? sel_be   : {BW{1'b1}};

  assign rvalid = rvalid_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_INIT;
      cnt_reg      <= '0;
      rvalid_reg   <= 1'b0;
      hit_reg      <= 1'b0;
      fwd_data_reg <= '0;
      fwd_be_reg   <= '0;
    end else begin
      rvalid_reg   <= rd_fire;
      hit_reg      <= rd_fire & wgrant & (radr == sel_adr);
      fwd_data_reg <= sel_data;
      fwd_be_reg   <= sel_be;
      case (state_reg)
        ST_INIT: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == AW'(DEPTH - 1)) begin
            state_reg <= ST_RUN;
          end
        end
        default: begin
          if (flush) begin
            state_reg <= ST_INIT;
            cnt_reg   <= '0;
          end
        end
      endcase
    end
  end

  // The SRAM is read-first, so a same-cycle write is merged lane by lane here.
  for (genvar gi = 0; gi < BW; gi++) begin : g_merge
    localparam int LO = gi * 8;
    localparam int HI = (gi * 8 + 8 > WIDTH) ? WIDTH - 1 : gi * 8 + 7;
    assign rdata[HI:LO] = (hit_reg & fwd_be_reg[gi]) ? fwd_data_reg[HI:LO] : rd1[HI:LO];
  end

endmodule
